// File: rtl/msg_tx_driver_pkg.sv
// Shared types and constants for the message transmit driver: FSM states,
// beat geometry and header field placement within the 128-bit header beat.
package msg_tx_driver_pkg;

    localparam int BEAT_W         = 128;
    localparam int BYTES_PER_BEAT = 16;

    localparam int HDR_SYNC_LSB  = 96;
    localparam int HDR_TYPE_LSB  = 92;
    localparam int HDR_CNT_LSB   = 64;
    localparam int HDR_SRC_LSB   = 56;
    localparam int HDR_DES_LSB   = 48;
    localparam int HDR_DTYPE_LSB = 40;
    localparam int HDR_DCH_LSB   = 32;
    localparam int HDR_LEN_LSB   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } tx_state_e;

    // Unlisted bit ranges ([91:80] and [15:0]) stay zero.
    function automatic logic [BEAT_W-1:0] build_header(
        input logic [31:0] sync_word,
        input logic [3:0]  frame_type,
        input logic [15:0] frame_cnt,
        input logic [7:0]  src_id,
        input logic [7:0]  des_id,
        input logic [7:0]  data_type,
        input logic [7:0]  data_channel,
        input logic [15:0] len
    );
        logic [BEAT_W-1:0] beat;
        beat = '0;
        beat[HDR_SYNC_LSB  +: 32] = sync_word;
        beat[HDR_TYPE_LSB  +: 4]  = frame_type;
        beat[HDR_CNT_LSB   +: 16] = frame_cnt;
        beat[HDR_SRC_LSB   +: 8]  = src_id;
        beat[HDR_DES_LSB   +: 8]  = des_id;
        beat[HDR_DTYPE_LSB +: 8]  = data_type;
        beat[HDR_DCH_LSB   +: 8]  = data_channel;
        beat[HDR_LEN_LSB   +: 16] = len;
        return beat;
    endfunction

endpackage

// File: rtl/msg_tx_driver_if.sv
// FIFO read side and beat output stream of the transmit driver.
interface msg_tx_driver_if;
    import msg_tx_driver_pkg::*;

    logic              rd_clk_o;
    logic              rd_en_o;
    logic [7:0]        din_i;
    logic [15:0]       data_count_i;
    logic              empty_i;
    logic              flow_valid_o;
    logic [BEAT_W-1:0] flow_data_o;

    modport master (
        output rd_clk_o, rd_en_o, flow_valid_o, flow_data_o,
        input  din_i, data_count_i, empty_i
    );

    modport slave (
        input  rd_clk_o, rd_en_o, flow_valid_o, flow_data_o,
        output din_i, data_count_i, empty_i
    );

endinterface

// File: rtl/msg_byte_packer.sv
// Packs a byte stream MSB-first into 128-bit beats; flush emits any partial
// beat (including a byte arriving in the same cycle) with zero low bytes.
module msg_byte_packer
    import msg_tx_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              flush,
    output logic [BEAT_W-1:0] beat_data,
    output logic              beat_valid
);

    localparam int IDX_W = $clog2(BYTES_PER_BEAT);

    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] acc;
    logic [BEAT_W-1:0] merged;
    logic [6:0]        byte_lsb;
    logic              last_slot;

    assign last_slot = (idx == IDX_W'(BYTES_PER_BEAT - 1));
    assign byte_lsb  = 7'((BYTES_PER_BEAT - 1 - int'(idx)) * 8);

    // The outgoing beat already contains the byte being accepted this cycle.
    always_comb begin
        merged = acc;
        if (byte_valid) begin
            merged[byte_lsb +: 8] = byte_in;
        end
    end

    assign beat_data  = merged;
    assign beat_valid = byte_valid ? (last_slot || flush) : (flush && (idx != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
        end else if (beat_valid || flush) begin
            idx <= '0;
            acc <= '0;
        end else if (byte_valid) begin
            idx <= idx + 1'b1;
            acc <= merged;
        end
    end

endmodule

// File: rtl/msg_tx_driver.sv
// Frame transmitter: on a start edge sends a header beat, then reads LEN bytes
// from a FIFO and streams them as 128-bit beats, ending with a done pulse.
module msg_tx_driver
    import msg_tx_driver_pkg::*;
#(
    parameter int ILA_CH  = 0,
    parameter int MAX_LEN = 1024
)(
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        transmit_start_pluse_i,
    output logic        send_done_o,
    input  logic [31:0] transmit_header,
    input  logic [3:0]  transmit_frame_type,
    input  logic [15:0] transmit_frame_cnt,
    input  logic [7:0]  transmit_src_id,
    input  logic [7:0]  transmit_des_id,
    input  logic [7:0]  transmit_data_type,
    input  logic [7:0]  transmit_data_channel,
    msg_tx_driver_if.master bus
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    if ((MAX_LEN % BYTES_PER_BEAT) != 0 || MAX_LEN > 65535 || ILA_CH < 0) begin : g_bad_param
        $error("msg_tx_driver: MAX_LEN must be a 16-bit multiple of 16 and ILA_CH non-negative");
    end

    tx_state_e         state, state_next;
    logic              start_q;
    logic              start_edge;
    logic [15:0]       start_len;
    logic [15:0]       len;
    logic [15:0]       req_cnt;
    logic              rd_en;
    logic              rd_en_d;
    logic              last_byte;
    logic [BEAT_W-1:0] pack_beat;
    logic              pack_valid;

    assign start_edge = transmit_start_pluse_i && !start_q;
    assign start_len  = (bus.data_count_i > MAX_LEN_W) ? MAX_LEN_W : bus.data_count_i;
    assign rd_en      = (state == ST_READ) && !bus.empty_i && (req_cnt < len);
    assign last_byte  = rd_en_d && (req_cnt == len);

    assign bus.rd_clk_o = sys_clk_i;
    assign bus.rd_en_o  = rd_en;
    assign send_done_o  = (state == ST_DONE);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // READ ends when the final requested byte lands in the packer, so the last
    // beat shows during FLUSH and the done pulse follows it directly.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_edge) state_next = ST_HEADER;
            ST_HEADER: state_next = (len == '0) ? ST_DONE : ST_READ;
            ST_READ:   if (last_byte) state_next = ST_FLUSH;
            ST_FLUSH:  state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // start_q resets high so a start level held across reset is not an edge.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q          <= 1'b1;
            len              <= '0;
            req_cnt          <= '0;
            rd_en_d          <= 1'b0;
            bus.flow_valid_o <= 1'b0;
            bus.flow_data_o  <= '0;
        end else begin
            start_q          <= transmit_start_pluse_i;
            rd_en_d          <= rd_en;
            bus.flow_valid_o <= 1'b0;
            if (state == ST_IDLE && start_edge) begin
                len              <= start_len;
                req_cnt          <= '0;
                bus.flow_valid_o <= 1'b1;
                bus.flow_data_o  <= build_header(transmit_header, transmit_frame_type,
                                                 transmit_frame_cnt, transmit_src_id,
                                                 transmit_des_id, transmit_data_type,
                                                 transmit_data_channel, start_len);
            end else begin
                if (rd_en) begin
                    req_cnt <= req_cnt + 16'd1;
                end
                if (pack_valid) begin
                    bus.flow_valid_o <= 1'b1;
                    bus.flow_data_o  <= pack_beat;
                end
            end
        end
    end

    msg_byte_packer u_packer (
        .clk        (sys_clk_i),
        .rst        (rst_i),
        .byte_in    (bus.din_i),
        .byte_valid (rd_en_d),
        .flush      (last_byte),
        .beat_data  (pack_beat),
        .beat_valid (pack_valid)
    );

endmodule

// File: tb/tb_msg_tx_driver.sv
// Self-checking bench: FIFO model, expected-beat queue built from frame rules,
// and one compare process checking outputs every cycle.
module tb_msg_tx_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        send_done;
    logic [31:0] hdr = '0;
    logic [3:0]  ftype = '0;
    logic [15:0] fcnt = '0;
    logic [7:0]  src = '0, des = '0, dtype = '0, dch = '0;

    msg_tx_driver_if bus();

    msg_tx_driver #(.ILA_CH(3), .MAX_LEN(1024)) dut (
        .sys_clk_i              (clk),
        .rst_i                  (rst),
        .transmit_start_pluse_i (start),
        .send_done_o            (send_done),
        .transmit_header        (hdr),
        .transmit_frame_type    (ftype),
        .transmit_frame_cnt     (fcnt),
        .transmit_src_id        (src),
        .transmit_des_id        (des),
        .transmit_data_type     (dtype),
        .transmit_data_channel  (dch),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   tx_bytes[$];
    logic [7:0]   fifo_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] cap_q[$];
    int           rd_count = 0;
    int           stall_at = -1;
    int           stall_left = 0;
    bit           stall_hit = 0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] model_header(input logic [15:0] len);
        return {hdr, ftype, 12'h000, fcnt, src, des, dtype, dch, len, 16'h0000};
    endfunction

    // FIFO: a read seen in one cycle presents its byte from the next cycle on.
    initial begin
        logic pend;
        bus.din_i = '0;
        bus.empty_i = 1'b1;
        bus.data_count_i = '0;
        forever begin
            @(negedge clk);
            pend = bus.rd_en_o;
            @(posedge clk);
            #1;
            if (pend) begin
                rd_count++;
                checkOutput("fifo_underflow", 128'(fifo_q.size() > 0), 128'd1);
                if (fifo_q.size() > 0) bus.din_i = fifo_q.pop_front();
            end
            if (stall_left > 0) begin
                stall_left--;
            end else if (stall_at >= 0 && rd_count == stall_at) begin
                stall_left = 10;
                stall_at = -1;
                stall_hit = 1;
            end
            bus.empty_i = (fifo_q.size() == 0) || (stall_left > 0);
        end
    end

    // Every beat must be the next expected one; done follows the frame's last beat.
    initial begin
        logic [127:0] last_data;
        logic [127:0] e;
        bit           done_exp;
        last_data = '0;
        done_exp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data = '0;
                done_exp = 0;
            end else begin
                checkOutput("send_done", 128'(send_done), 128'(done_exp));
                done_exp = 0;
                checkOutput("rd_while_empty", 128'(bus.rd_en_o & bus.empty_i), 128'd0);
                if (bus.flow_valid_o) begin
                    cap_q.push_back(bus.flow_data_o);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: actual=%h required=no beat", bus.flow_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", bus.flow_data_o, e);
                        last_data = e;
                        if (exp_q.size() == 0) done_exp = 1;
                    end
                end else begin
                    checkOutput("data_hold", bus.flow_data_o, last_data);
                end
            end
        end
    end

    task automatic setRandomFields();
        hdr = $urandom;
        ftype = 4'($urandom);
        fcnt = 16'($urandom);
        src = 8'($urandom);
        des = 8'($urandom);
        dtype = 8'($urandom);
        dch = 8'($urandom);
    endtask

    task automatic loadFrame(input int count);
        int           len;
        logic [127:0] beat;
        len = (count > 1024) ? 1024 : count;
        fifo_q = tx_bytes;
        rd_count = 0;
        cap_q.delete();
        exp_q.delete();
        exp_q.push_back(model_header(16'(len)));
        for (int b = 0; b < (len + 15) / 16; b++) begin
            beat = '0;
            for (int k = 0; k < 16; k++) begin
                if (b * 16 + k < len) beat[127 - 8 * k -: 8] = tx_bytes[b * 16 + k];
            end
            exp_q.push_back(beat);
        end
        bus.data_count_i = 16'(count);
    endtask

    task automatic applyStimulus(input int count, input bit jitter);
        int len;
        int n;
        len = (count > 1024) ? 1024 : count;
        @(negedge clk);
        #1;
        loadFrame(count);
        start = 1'b1;
        @(negedge clk);
        checkOutput("hdr_latency", 128'(bus.flow_valid_o), 128'd1);
        for (n = 0; n < 6000; n++) begin
            if (send_done) break;
            #1;
            if (jitter) bus.data_count_i = 16'($urandom_range(0, 65535));
            @(negedge clk);
        end
        checkOutput("done_timeout", 128'(n < 6000), 128'd1);
        checkOutput("rd_count", 128'(rd_count), 128'(len));
        checkOutput("beats_left", 128'(exp_q.size()), 128'd0);
        repeat (5) @(negedge clk);
        #1;
        start = 1'b0;
        stall_at = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_en"}, 128'(bus.rd_en_o), 128'd0);
        checkOutput({tag, "_flow_valid"}, 128'(bus.flow_valid_o), 128'd0);
        checkOutput({tag, "_flow_data"}, bus.flow_data_o, 128'd0);
        checkOutput({tag, "_send_done"}, 128'(send_done), 128'd0);
    endtask

    initial begin
        logic [127:0] b;
        int           n;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        checkOutput("rd_clk", 128'(bus.rd_clk_o), 128'(clk));
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        hdr = 32'hFDF7EB90; ftype = 4'h1; fcnt = 16'h0005;
        src = 8'h01; des = 8'h02; dtype = 8'h03; dch = 8'h04;
        tx_bytes.delete();
        applyStimulus(0, 0);
        checkOutput("hdr_only_count", 128'(cap_q.size()), 128'd1);
        checkOutput("hdr_literal", cap_q[0], 128'hFDF7EB90_1000_0005_01020304_0000_0000);

        tx_bytes.delete();
        for (int i = 0; i < 40; i++) tx_bytes.push_back(8'(i));
        applyStimulus(32, 1);
        checkOutput("len32_count", 128'(cap_q.size()), 128'd3);
        checkOutput("len32_beat0", cap_q[1], 128'h000102030405060708090A0B0C0D0E0F);
        checkOutput("len32_beat1", cap_q[2], 128'h101112131415161718191A1B1C1D1E1F);

        tx_bytes.delete();
        for (int i = 0; i < 8; i++) tx_bytes.push_back(8'(8'hAA + i));
        applyStimulus(5, 0);
        checkOutput("len5_count", 128'(cap_q.size()), 128'd2);
        b = cap_q[0];
        checkOutput("len5_hdr_len", 128'(b[31:16]), 128'h0005);
        checkOutput("len5_partial", cap_q[1], 128'hAAABACADAE0000000000000000000000);

        setRandomFields();
        tx_bytes.delete();
        for (int i = 0; i < 40; i++) tx_bytes.push_back(8'($urandom));
        stall_hit = 0;
        stall_at = 8;
        applyStimulus(40, 1);
        checkOutput("stall_seen", 128'(stall_hit), 128'd1);

        setRandomFields();
        tx_bytes.delete();
        for (int i = 0; i < 1100; i++) tx_bytes.push_back(8'($urandom));
        applyStimulus(2000, 0);
        checkOutput("trunc_count", 128'(cap_q.size()), 128'd65);
        b = cap_q[0];
        checkOutput("trunc_hdr_len", 128'(b[31:16]), 128'h0400);

        for (int f = 0; f < 6; f++) begin
            int count;
            setRandomFields();
            count = $urandom_range(0, 70);
            tx_bytes.delete();
            for (int i = 0; i < count + 4; i++) tx_bytes.push_back(8'($urandom));
            stall_at = (count > 4) ? int'($urandom_range(1, count - 1)) : -1;
            applyStimulus(count, 1);
        end

        setRandomFields();
        tx_bytes.delete();
        for (int i = 0; i < 64; i++) tx_bytes.push_back(8'($urandom));
        @(negedge clk);
        #1;
        loadFrame(64);
        start = 1'b1;
        for (n = 0; n < 200 && rd_count < 10; n++) @(negedge clk);
        checkOutput("abort_in_read", 128'(rd_count >= 10), 128'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkResetOutputs("abort");
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("no_retrigger", 128'(cap_q.size()), 128'd1);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);

        setRandomFields();
        tx_bytes.delete();
        for (int i = 0; i < 24; i++) tx_bytes.push_back(8'($urandom));
        applyStimulus(20, 1);
        checkOutput("post_abort_count", 128'(cap_q.size()), 128'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
